// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-serial load/store responder owning a little-endian data RAM
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   memory_start       request, held by the initiator until it samples memory_done
//   sel_mem_operation  0 = load, 1 = store
//   funct3             size in [1:0] (1/2/4/8 bytes), [2]=1 selects zero-extension on loads
//   addr, wdata        byte address and LSB-aligned store data
//   rdata              extended load result, valid with memory_done, held until the next load completes
//   memory_done        one-cycle completion pulse
//   busy               high while an access is in flight or completing
//   mem_fault          out-of-range access flag, present only when DMEM_FAULT_EN is defined
// Parameters: DEPTH_LOG2 (RAM is 2**DEPTH_LOG2 bytes), INIT_FILE (RAM image name).
// Build option: DMEM_FAULT_EN turns out-of-range accesses into faults instead of wrapping.
module data_memory_ctrl #(
  parameter int DEPTH_LOG2 = 12,
  parameter INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_start,
  input  logic        sel_mem_operation,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        memory_done,
  output logic        busy
`ifdef DMEM_FAULT_EN
  ,
  output logic        mem_fault
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] a_addr, idx;
  logic [63:0] a_wdata, acc, rdata_q, ext;
  logic [2:0] a_f3, cnt;
  logic a_op, armed, go, last, start_fault, u;
`ifdef DMEM_FAULT_EN
  logic a_fault;
  logic [3:0] nb_start;
  assign nb_start = 4'd1 << funct3[1:0];
  assign start_fault = (addr[63:DEPTH_LOG2] != '0) ||
    (({1'b0, addr[DEPTH_LOG2-1:0]} + (DEPTH_LOG2+1)'(nb_start)) > (DEPTH_LOG2+1)'(2**DEPTH_LOG2));
  assign mem_fault = (state == DONE) && a_fault;
`else
  assign start_fault = 1'b0;
`endif
  // armed blocks a request still held high after DONE from starting a second access
  assign go = (state == IDLE) && memory_start && armed;
  assign last = cnt == 3'((4'd1 << a_f3[1:0]) - 4'd1);
  assign idx = a_addr + DEPTH_LOG2'(cnt);
  assign memory_done = state == DONE;
  assign busy = state != IDLE;
  assign u = a_f3[2];
  always_comb begin
    ext = a_f3[1:0] == 2'd0 ? {{56{!u && acc[7]}}, acc[7:0]} :
          a_f3[1:0] == 2'd1 ? {{48{!u && acc[15]}}, acc[15:0]} :
          a_f3[1:0] == 2'd2 ? {{32{!u && acc[31]}}, acc[31:0]} : acc;
    state_nx = state == IDLE   ? (go ? (start_fault ? DONE : ACCESS) : IDLE) :
               state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  // the live result is shown combinationally in DONE and captured for holding afterwards
  assign rdata = (state == DONE && !a_op) ? ext : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed <= 1'b0;
      cnt <= '0;
      acc <= '0;
      rdata_q <= '0;
      a_addr <= '0;
      a_wdata <= '0;
      a_f3 <= '0;
      a_op <= 1'b0;
`ifdef DMEM_FAULT_EN
      a_fault <= 1'b0;
`endif
    end else begin
      armed <= go ? 1'b0 : (state == IDLE && !memory_start) ? 1'b1 : armed;
      if (go) begin
        a_addr <= addr[DEPTH_LOG2-1:0];
        a_wdata <= wdata;
        a_f3 <= funct3;
        a_op <= sel_mem_operation;
        cnt <= '0;
        acc <= '0;
`ifdef DMEM_FAULT_EN
        a_fault <= start_fault;
`endif
      end
      if (state == ACCESS) begin
        cnt <= cnt + 3'd1;
        if (!a_op) acc[{cnt, 3'b000} +: 8] <= mem[idx];
      end
      if (state == DONE && !a_op) rdata_q <= ext;
    end
  // RAM survives reset; a store interrupted by reset keeps the bytes already written
  always_ff @(posedge clk)
    if (state == ACCESS && a_op) mem[idx] <= a_wdata[{cnt, 3'b000} +: 8];
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, memory_start = 1'b0, sel_mem_operation = 1'b0;
  logic [2:0] funct3 = '0;
  logic [63:0] addr = '0, wdata = '0, rdata;
  logic memory_done, busy;
  int n_chk = 0, n_fail = 0, lat;
  logic [63:0] rd;
`ifdef DMEM_FAULT_EN
  logic mem_fault, flt;
`endif
  always #5 clk = ~clk;
  data_memory_ctrl dut (
    .clk(clk), .rst_n(rst_n), .memory_start(memory_start), .sel_mem_operation(sel_mem_operation),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .memory_done(memory_done), .busy(busy)
`ifdef DMEM_FAULT_EN
    , .mem_fault(mem_fault)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic op, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                     output int l, output logic [63:0] r);
    @(negedge clk);
    sel_mem_operation = op;
    funct3 = f3;
    addr = a;
    wdata = wd;
    memory_start = 1'b1;
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!memory_done && l < 20);
    if (!memory_done) check("done_timeout", 64'(memory_done), 64'd1);
    r = rdata;
`ifdef DMEM_FAULT_EN
    flt = mem_fault;
`endif
  endtask
  task automatic idle2();
    @(negedge clk);
    memory_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 64'd0);
    check("rst_done", 64'(memory_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run(1'b1, 3'b011, 64'h10, 64'h8877665544332211, lat, rd);
    check("sd_lat", 64'(lat), 64'd9);
    idle2();
    run(1'b0, 3'b011, 64'h10, 64'h0, lat, rd);
    check("ld_lat", 64'(lat), 64'd9);
    check("ld", rd, 64'h8877665544332211);
    idle2();
    run(1'b0, 3'b000, 64'h17, 64'h0, lat, rd);
    check("lb", rd, 64'hFFFFFFFFFFFFFF88);
    check("lb_lat", 64'(lat), 64'd2);
    idle2();
    run(1'b0, 3'b100, 64'h17, 64'h0, lat, rd);
    check("lbu", rd, 64'h0000000000000088);
    idle2();
    run(1'b0, 3'b001, 64'h16, 64'h0, lat, rd);
    check("lh", rd, 64'hFFFFFFFFFFFF8877);
    idle2();
    run(1'b1, 3'b010, 64'h13, 64'hFFFFFFFFDEADBEEF, lat, rd);
    check("sw_lat", 64'(lat), 64'd5);
    idle2();
    run(1'b0, 3'b110, 64'h13, 64'h0, lat, rd);
    check("lwu", rd, 64'h00000000DEADBEEF);
    idle2();
    run(1'b0, 3'b010, 64'h13, 64'h0, lat, rd);
    check("lw", rd, 64'hFFFFFFFFDEADBEEF);
    idle2();
    run(1'b0, 3'b100, 64'h12, 64'h0, lat, rd);
    check("byte12", rd, 64'h33);
    idle2();
    run(1'b0, 3'b100, 64'h17, 64'h0, lat, rd);
    check("byte17", rd, 64'h88);
    idle2();
    run(1'b0, 3'b111, 64'h10, 64'h0, lat, rd);
    check("ld_f3_111", rd, 64'h88DEADBEEF332211);
    idle2();
    run(1'b1, 3'b011, 64'h40, 64'hA7A6A5A4A3A2A1A0, lat, rd);
    check("store_keeps_rdata", rd, 64'h88DEADBEEF332211);
    idle2();
    run(1'b0, 3'b100, 64'h10, 64'h0, lat, rd);
    check("hold_first", rd, 64'h11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_busy", 64'(busy), 64'd0);
      check("hold_done", 64'(memory_done), 64'd0);
    end
    idle2();
    run(1'b0, 3'b100, 64'h11, 64'h0, lat, rd);
    check("rearm_lat", 64'(lat), 64'd2);
    check("rearm_val", rd, 64'h22);
    idle2();
    @(negedge clk);
    sel_mem_operation = 1'b1;
    funct3 = 3'b011;
    addr = 64'h40;
    wdata = 64'h0706050403020100;
    memory_start = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(memory_done), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    memory_start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run(1'b0, 3'b011, 64'h40, 64'h0, lat, rd);
    check("partial_store", rd, 64'hA7A6A5A4A3020100);
    idle2();
    run(1'b1, 3'b000, 64'hFFF, 64'h3C, lat, rd);
    idle2();
    run(1'b1, 3'b001, 64'hFFF, 64'hBBAA, lat, rd);
`ifdef DMEM_FAULT_EN
    check("fault_lat", 64'(lat), 64'd1);
    check("fault_flag", 64'(flt), 64'd1);
    idle2();
    run(1'b0, 3'b100, 64'hFFF, 64'h0, lat, rd);
    check("fault_unchanged", rd, 64'h3C);
    check("fault_clear", 64'(flt), 64'd0);
`else
    check("wrap_lat", 64'(lat), 64'd3);
    idle2();
    run(1'b0, 3'b100, 64'hFFF, 64'h0, lat, rd);
    check("wrap_top", rd, 64'hAA);
    idle2();
    run(1'b0, 3'b100, 64'h0, 64'h0, lat, rd);
    check("wrap_zero", rd, 64'hBB);
`endif
    idle2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
